// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the parametrised UART core
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Callers zero-extend their payload to 9 bits, so unused upper bits do not affect the result
  function automatic logic parity9(input logic [8:0] d);
    return ^d;
  endfunction

  // Occupancy counter width for a FIFO able to hold 0..depth entries
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular FIFO with first-word fall-through head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en   = push_i && (!full_o || rd_en);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised UART with TX/RX FIFOs and 16x oversampling receiver
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 27,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_wr,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_full,
  output logic [lvl_w(TX_DEPTH)-1:0]    tx_level,
  output logic                          tx_busy,
  output logic                          txd,
  input  logic                          rxd,
  input  logic                          rx_rd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_empty,
  output logic [lvl_w(RX_DEPTH)-1:0]    rx_level,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  output logic                          tx_drop,
  input  logic                          err_clr
);

  localparam int  TW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic ODD  = (PARITY_ODD != 0);

  // ---------------- tick generator ----------------
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  assign tick = (tick_cnt_q == TW'(BAUD_DIV - 1));

  // Free-running oversample divider shared by both directions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  tx_state_e              tx_state_q;
  logic [3:0]             tx_sub_q, tx_bit_q;
  logic [DATA_BITS-1:0]   tx_shift_q, txf_dout;
  logic                   tx_par_q, txd_q, txf_empty, tx_pop, tx_last_tick;

  assign tx_last_tick = tick && (tx_sub_q == 4'(OVERSAMPLE - 1));
  // Reload straight out of the final stop tick so back-to-back frames have no idle gap
  assign tx_pop = !txf_empty && ((tx_state_q == TX_IDLE) ||
                  (tx_state_q == TX_STOP && tx_last_tick && tx_bit_q == 4'(STOP_BITS - 1)));

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push_i(tx_wr && !tx_full), .pop_i(tx_pop),
    .din_i(tx_data), .dout_o(txf_dout), .full_o(tx_full), .empty_o(txf_empty), .level_o(tx_level)
  );

  // Serialiser: every state spans 16 ticks, txd is registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else if (tx_pop) begin
      tx_shift_q <= txf_dout;
      tx_par_q   <= parity9(9'(txf_dout)) ^ ODD;
      tx_state_q <= TX_START;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b0;
    end else if (tx_state_q != TX_IDLE && tick) begin
      tx_sub_q <= tx_sub_q + 1'b1;
      if (tx_last_tick) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == 4'(DATA_BITS - 1)) begin
              tx_bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_state_q <= TX_PARITY;
                txd_q      <= tx_par_q;
              end else begin
                tx_state_q <= TX_STOP;
                txd_q      <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end
          TX_PARITY: begin
            tx_state_q <= TX_STOP;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
          end
          TX_STOP: begin
            if (tx_bit_q == 4'(STOP_BITS - 1)) tx_state_q <= TX_IDLE;
            else                               tx_bit_q   <= tx_bit_q + 1'b1;
          end
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (tx_state_q != TX_IDLE) || !txf_empty;

  // ---------------- receiver ----------------
  rx_state_e              rx_state_q;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q, rx_perr_q, rx_hold_en;
  logic [3:0]             rx_sub_q, rx_bit_q;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_hold_q;
  logic [DATA_BITS+1:0]   rxf_dout;
  logic                   rx_mid, rx_push, rx_full;

  assign rx_mid  = tick && (rx_sub_q == 4'(MID_SAMPLE));
  assign rx_push = (rx_state_q == RX_STOP) && rx_mid;

  // Two-flop synchroniser plus edge history; resets to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Deserialiser: samples at mid-bit, pushes the entry at the stop sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else if (rx_state_q == RX_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_q <= RX_START;
        rx_sub_q   <= '0;
        rx_perr_q  <= 1'b0;
      end
    end else if (tick) begin
      rx_sub_q <= rx_sub_q + 1'b1;
      case (rx_state_q)
        RX_START: begin
          if (rx_mid && rx_s2_q) rx_state_q <= RX_IDLE;
          else if (rx_sub_q == 4'(OVERSAMPLE - 1)) begin
            rx_state_q <= RX_DATA;
            rx_bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_mid) rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_sub_q == 4'(OVERSAMPLE - 1)) begin
            if (rx_bit_q == 4'(DATA_BITS - 1))
              rx_state_q <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            else
              rx_bit_q <= rx_bit_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_mid) rx_perr_q <= rx_s2_q ^ parity9(9'(rx_shift_q)) ^ ODD;
          if (rx_sub_q == 4'(OVERSAMPLE - 1)) rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_mid) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_rd),
    .din_i({rx_perr_q, !rx_s2_q, rx_shift_q}), .dout_o(rxf_dout),
    .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  assign rx_hold_en = rx_rd && !rx_empty;

  // Remember the last popped byte so rx_data stays stable while the FIFO is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          rx_hold_q <= '0;
    else if (rx_hold_en) rx_hold_q <= rxf_dout[DATA_BITS-1:0];
  end

  assign rx_data       = rx_empty ? rx_hold_q : rxf_dout[DATA_BITS-1:0];
  assign rx_frame_err  = !rx_empty && rxf_dout[DATA_BITS];
  assign rx_parity_err = !rx_empty && rxf_dout[DATA_BITS+1];

  // Sticky error flags; a same-cycle set beats err_clr
  logic rx_overrun_q, tx_drop_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_rd) rx_overrun_q <= 1'b1;
      else if (err_clr)                 rx_overrun_q <= 1'b0;
      if (tx_wr && tx_full)             tx_drop_q    <= 1'b1;
      else if (err_clr)                 tx_drop_q    <= 1'b0;
    end
  end

  assign rx_overrun = rx_overrun_q;
  assign tx_drop    = tx_drop_q;

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - directed self-checking bench for uart_core_param
module tb_uart_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  // u0: 8N1, depth-4 FIFOs; u1: 8E1, default depths. Both at BAUD_DIV=4 (64 clk per bit).
  logic       tx_wr0, rx_rd0, err_clr0, drv0, lb0, rxd0;
  logic [7:0] tx_data0, rx_data0;
  logic       tx_full0, tx_busy0, txd0, rx_empty0, rx_frame_err0, rx_parity_err0, rx_overrun0, tx_drop0;
  logic [2:0] tx_level0, rx_level0;

  logic       tx_wr1, rx_rd1, err_clr1, drv1, lb1, rxd1;
  logic [7:0] tx_data1, rx_data1;
  logic       tx_full1, tx_busy1, txd1, rx_empty1, rx_frame_err1, rx_parity_err1, rx_overrun1, tx_drop1;
  logic [4:0] tx_level1, rx_level1;

  assign rxd0 = lb0 ? txd0 : drv0;
  assign rxd1 = lb1 ? txd1 : drv1;

  uart_core_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                    .BAUD_DIV(4), .TX_DEPTH(4), .RX_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .tx_wr(tx_wr0), .tx_data(tx_data0), .tx_full(tx_full0),
    .tx_level(tx_level0), .tx_busy(tx_busy0), .txd(txd0), .rxd(rxd0), .rx_rd(rx_rd0),
    .rx_data(rx_data0), .rx_empty(rx_empty0), .rx_level(rx_level0), .rx_frame_err(rx_frame_err0),
    .rx_parity_err(rx_parity_err0), .rx_overrun(rx_overrun0), .tx_drop(tx_drop0), .err_clr(err_clr0)
  );

  uart_core_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                    .BAUD_DIV(4), .TX_DEPTH(16), .RX_DEPTH(16)) u1 (
    .clk(clk), .reset(reset), .tx_wr(tx_wr1), .tx_data(tx_data1), .tx_full(tx_full1),
    .tx_level(tx_level1), .tx_busy(tx_busy1), .txd(txd1), .rxd(rxd1), .rx_rd(rx_rd1),
    .rx_data(rx_data1), .rx_empty(rx_empty1), .rx_level(rx_level1), .rx_frame_err(rx_frame_err1),
    .rx_parity_err(rx_parity_err1), .rx_overrun(rx_overrun1), .tx_drop(tx_drop1), .err_clr(err_clr1)
  );

  // Every completed high run on u0's txd during the burst must be a whole number of bit times
  int mon0 = 0, run0 = 0, bad_runs0 = 0;
  always @(negedge clk) begin
    if (txd0) run0 = run0 + 1;
    else begin
      if (mon0 != 0 && run0 != 0 && (run0 % 64) != 0) bad_runs0 = bad_runs0 + 1;
      run0 = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_write(input bit which, input logic [7:0] d);
    @(negedge clk);
    if (which) begin tx_wr1 = 1'b1; tx_data1 = d; end else begin tx_wr0 = 1'b1; tx_data0 = d; end
    @(negedge clk);
    tx_wr0 = 1'b0; tx_wr1 = 1'b0;
  endtask

  task automatic rx_pop(input bit which);
    @(negedge clk);
    if (which) rx_rd1 = 1'b1; else rx_rd0 = 1'b1;
    @(negedge clk);
    rx_rd0 = 1'b0; rx_rd1 = 1'b0;
  endtask

  task automatic wait_txd(input bit which, input logic v, input int lim, input string tag);
    int n = 0;
    while (((which ? txd1 : txd0) !== v) && n < lim) begin @(negedge clk); n++; end
    chk(tag, which ? txd1 : txd0, v);
  endtask

  task automatic wait_rx(input bit which, input int lim, input string tag);
    int n = 0;
    while ((which ? rx_empty1 : rx_empty0) && n < lim) begin @(negedge clk); n++; end
    chk(tag, which ? rx_empty1 : rx_empty0, 0);
  endtask

  task automatic drive(input bit which, input logic v, input int cyc);
    if (which) drv1 = v; else drv0 = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive(which, 1'b0, 64);
    for (int i = 0; i < 8; i++) drive(which, d[i], 64);
    if (has_par) drive(which, par, 64);
    drive(which, stop, 64);
    drive(which, 1'b1, 64);
  endtask

  initial begin
    int         n;
    logic [7:0] exp_b;
    reset = 1'b0;
    tx_wr0 = 0; rx_rd0 = 0; err_clr0 = 0; drv0 = 1; lb0 = 0; tx_data0 = '0;
    tx_wr1 = 0; rx_rd1 = 0; err_clr1 = 0; drv1 = 1; lb1 = 0; tx_data1 = '0;
    repeat (3) @(negedge clk);

    // reset state: {txd, tx_full, rx_empty, ferr, perr, overrun, drop, busy}
    chk("reset_flags", {txd0, tx_full0, rx_empty0, rx_frame_err0, rx_parity_err0,
                        rx_overrun0, tx_drop0, tx_busy0}, 8'b1010_0000);
    chk("reset_levels", {tx_level0, rx_level0}, 6'd0);
    chk("reset_rx_data", rx_data0, 8'h00);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 waveform of 0xA5 on u0
    tx_write(0, 8'hA5);
    wait_txd(0, 1'b0, 200, "tx_start_seen");
    n = 0;
    while (!txd0 && n < 100) begin @(negedge clk); n++; end
    chk("tx_start_len_61_to_64", (n >= 61 && n <= 64), 1);
    repeat (32) @(negedge clk);
    exp_b = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_bit%0d", i), txd0, exp_b[i]);
      repeat (64) @(negedge clk);
    end
    chk("tx_stop_high", txd0, 1);
    chk("tx_busy_in_stop", tx_busy0, 1);
    repeat (36) @(negedge clk);
    chk("tx_busy_after_stop", tx_busy0, 0);
    chk("tx_idle_high", txd0, 1);

    // 8E1 loopback on u1: parity bit of 0xA5 is 0
    lb1 = 1'b1;
    tx_write(1, 8'hA5);
    wait_txd(1, 1'b0, 200, "par_start_seen");
    wait_txd(1, 1'b1, 100, "par_d0_seen");
    repeat (544) @(negedge clk);
    chk("par_bit_on_wire", txd1, 0);
    wait_rx(1, 400, "par_rx_arrived");
    chk("par_rx_data", rx_data1, 8'hA5);
    chk("par_rx_perr", rx_parity_err1, 0);
    chk("par_rx_ferr", rx_frame_err1, 0);
    rx_pop(1);
    chk("par_rx_popped", rx_empty1, 1);
    repeat (100) @(negedge clk);
    lb1 = 1'b0;

    // corrupted parity: 0x3C needs even parity 0, send 1
    send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
    chk("badpar_level", rx_level1, 1);
    chk("badpar_data", rx_data1, 8'h3C);
    chk("badpar_perr", rx_parity_err1, 1);
    chk("badpar_ferr", rx_frame_err1, 0);
    rx_pop(1);

    // 3-tick glitch is a false start
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 200);
    chk("glitch_rx_empty", rx_empty0, 1);
    chk("glitch_rx_level", rx_level0, 0);

    // stop bit 0 -> pushed with frame error
    send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
    chk("ferr_level", rx_level0, 1);
    chk("ferr_data", rx_data0, 8'h5A);
    chk("ferr_flag", rx_frame_err0, 1);
    chk("ferr_perr", rx_parity_err0, 0);
    rx_pop(0);
    chk("ferr_popped_empty", rx_empty0, 1);
    chk("rx_data_held", rx_data0, 8'h5A);

    // TX burst of 6 into depth 4 with loopback into depth-4 RX
    lb0 = 1'b1;
    @(negedge clk);
    tx_wr0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tx_data0 = 8'(i);
      @(negedge clk);
    end
    tx_wr0 = 1'b0;
    mon0 = 1;
    chk("burst_tx_level", tx_level0, 4);
    chk("burst_tx_full", tx_full0, 1);
    chk("burst_tx_drop", tx_drop0, 1);
    n = 0;
    while (tx_busy0 && n < 5000) begin @(negedge clk); n++; end
    chk("burst_tx_done", tx_busy0, 0);
    mon0 = 0;
    chk("burst_no_gap", bad_runs0, 0);
    repeat (20) @(negedge clk);
    chk("ovr_rx_level", rx_level0, 4);
    chk("ovr_flag", rx_overrun0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_read%0d", i), rx_data0, 32'(i));
      rx_pop(0);
    end
    chk("ovr_drained", rx_empty0, 1);
    @(negedge clk) err_clr0 = 1'b1;
    @(negedge clk) err_clr0 = 1'b0;
    chk("errclr_overrun", rx_overrun0, 0);
    chk("errclr_drop", tx_drop0, 0);

    // reset in the middle of DATA
    tx_write(0, 8'hF0);
    tx_write(0, 8'h0F);
    wait_txd(0, 1'b0, 200, "rst_start_seen");
    repeat (100) @(negedge clk);
    chk("rst_pre_txd_low", txd0, 0);
    reset = 1'b0;
    #1;
    chk("rst_txd_high", txd0, 1);
    chk("rst_levels", {tx_level0, rx_level0}, 6'd0);
    chk("rst_busy", tx_busy0, 0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    tx_write(0, 8'h3C);
    wait_rx(0, 1200, "post_rst_rx_arrived");
    chk("post_rst_data", rx_data0, 8'h3C);
    chk("post_rst_ferr", rx_frame_err0, 0);
    chk("post_rst_level", rx_level0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
